// File: rtl/regfile_ctrl_pkg.sv
// Shared widths, FSM state type and debug request payload for the register-file port controller.
package regfile_ctrl_pkg;

   localparam int unsigned REG_W       = 5;
   localparam int unsigned DATA_W      = 32;
   localparam int unsigned RF_LAST_IDX = 31;

   typedef enum logic [1:0] {
      CLEAR  = 2'd0,
      IDLE   = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } rfc_state_t;

   typedef struct packed {
      logic              write;
      logic [REG_W-1:0]  addr;
      logic [DATA_W-1:0] wdata;
   } dbg_req_t;

endpackage

// File: rtl/regfile_port_ctrl.sv
// Owns the register-file write port and read port 1: zero-clears x1..x31 after reset,
// then shares the ports between the core (pass-through) and single debug accesses.
module regfile_port_ctrl
   import regfile_ctrl_pkg::*;
#(
   parameter bit CLEAR_ON_RESET = 1'b1
)
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic [REG_W-1:0]  core_raddr1,
   input  logic [REG_W-1:0]  core_raddr2,
   input  logic              core_we,
   input  logic [REG_W-1:0]  core_waddr,
   input  logic [DATA_W-1:0] core_wdata,
   output logic              core_stall,
   input  logic              dbg_req_valid,
   output logic              dbg_req_ready,
   input  logic              dbg_req_write,
   input  logic [REG_W-1:0]  dbg_req_addr,
   input  logic [DATA_W-1:0] dbg_req_wdata,
   output logic              dbg_rsp_valid,
   input  logic              dbg_rsp_ready,
   output logic [DATA_W-1:0] dbg_rsp_rdata,
   output logic [REG_W-1:0]  rf_raddr1,
   output logic [REG_W-1:0]  rf_raddr2,
   output logic              rf_we,
   output logic [REG_W-1:0]  rf_waddr,
   output logic [DATA_W-1:0] rf_wdata,
   input  logic [DATA_W-1:0] rf_rdata1
);

   rfc_state_t        r_state;
   logic [REG_W-1:0]  r_clr_cnt;
   dbg_req_t          r_req;
   logic [DATA_W-1:0] r_rsp_rdata;
   logic              w_req_to_x0;

   assign w_req_to_x0 = (r_req.addr == '0);

   // Read port 2 is never shared.
   assign rf_raddr2 = core_raddr2;

   // Controller state, clear counter, latched debug request and response data.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         if (CLEAR_ON_RESET) begin
            r_state <= CLEAR;
         end else begin
            r_state <= IDLE;
         end
         r_clr_cnt   <= REG_W'(1);
         r_req       <= '0;
         r_rsp_rdata <= '0;
      end else begin
         case (r_state)
            CLEAR: begin
               r_clr_cnt <= r_clr_cnt + REG_W'(1);
               if (r_clr_cnt == REG_W'(RF_LAST_IDX)) begin
                  r_state <= IDLE;
               end
            end
            IDLE: begin
               if (dbg_req_valid) begin
                  r_req.write <= dbg_req_write;
                  r_req.addr  <= dbg_req_addr;
                  r_req.wdata <= dbg_req_wdata;
                  r_state     <= ACCESS;
               end
            end
            ACCESS: begin
               // x0 always reads as zero; writes report zero data.
               if (r_req.write || w_req_to_x0) begin
                  r_rsp_rdata <= '0;
               end else begin
                  r_rsp_rdata <= rf_rdata1;
               end
               r_state <= RESP;
            end
            RESP: begin
               if (dbg_rsp_ready) begin
                  r_state <= IDLE;
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   // Port mux and handshake decode; reset forces every side effect off.
   always_comb begin
      rf_raddr1     = core_raddr1;
      rf_we         = 1'b0;
      rf_waddr      = core_waddr;
      rf_wdata      = core_wdata;
      core_stall    = 1'b1;
      dbg_req_ready = 1'b0;
      dbg_rsp_valid = 1'b0;
      dbg_rsp_rdata = r_rsp_rdata;

      case (r_state)
         CLEAR: begin
            rf_we    = 1'b1;
            rf_waddr = r_clr_cnt;
            rf_wdata = '0;
         end
         IDLE: begin
            rf_we         = core_we;
            core_stall    = 1'b0;
            dbg_req_ready = 1'b1;
         end
         ACCESS: begin
            rf_raddr1 = r_req.addr;
            rf_we     = r_req.write && !w_req_to_x0;
            rf_waddr  = r_req.addr;
            rf_wdata  = r_req.wdata;
         end
         RESP: begin
            dbg_rsp_valid = 1'b1;
         end
         default: begin
            rf_we = 1'b0;
         end
      endcase

      if (!rst_n) begin
         rf_we         = 1'b0;
         core_stall    = 1'b1;
         dbg_req_ready = 1'b0;
         dbg_rsp_valid = 1'b0;
         dbg_rsp_rdata = '0;
      end
   end

endmodule

// File: tb/tb_regfile_port_ctrl.sv
// Bench for regfile_port_ctrl: behavioural register file, cycle compare against a
// transaction-level model, directed scenarios with literal expectations, then random traffic.
module tb_regfile_port_ctrl;

   localparam int unsigned RW = 5;
   localparam int unsigned DW = 32;

   logic          clk;
   logic          rst_n;
   logic [RW-1:0] core_raddr1, core_raddr2, core_waddr;
   logic          core_we;
   logic [DW-1:0] core_wdata;
   logic          core_stall;
   logic          dbg_req_valid, dbg_req_ready, dbg_req_write;
   logic [RW-1:0] dbg_req_addr;
   logic [DW-1:0] dbg_req_wdata;
   logic          dbg_rsp_valid, dbg_rsp_ready;
   logic [DW-1:0] dbg_rsp_rdata;
   logic [RW-1:0] rf_raddr1, rf_raddr2, rf_waddr;
   logic          rf_we;
   logic [DW-1:0] rf_wdata, rf_rdata1;

   int n_checks = 0;
   int n_fail   = 0;

   regfile_port_ctrl #(.CLEAR_ON_RESET(1'b1)) dut (
      .clk(clk), .rst_n(rst_n),
      .core_raddr1(core_raddr1), .core_raddr2(core_raddr2),
      .core_we(core_we), .core_waddr(core_waddr), .core_wdata(core_wdata),
      .core_stall(core_stall),
      .dbg_req_valid(dbg_req_valid), .dbg_req_ready(dbg_req_ready),
      .dbg_req_write(dbg_req_write), .dbg_req_addr(dbg_req_addr),
      .dbg_req_wdata(dbg_req_wdata),
      .dbg_rsp_valid(dbg_rsp_valid), .dbg_rsp_ready(dbg_rsp_ready),
      .dbg_rsp_rdata(dbg_rsp_rdata),
      .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_we(rf_we),
      .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_rdata1(rf_rdata1)
   );

   // Behavioural stand-in for Registers: no reset, x0 hardwired to zero.
   logic [DW-1:0] rf_mem [32];
   always @(posedge clk) begin
      if (rf_we && rf_waddr != '0) rf_mem[rf_waddr] <= rf_wdata;
   end
   assign rf_rdata1 = (rf_raddr1 == '0) ? '0 : rf_mem[rf_raddr1];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1);
   end

   task automatic check(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=0x%08h required=0x%08h", nm, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // ---------------- reference model ----------------
   // m_clear: next register the zero walk writes (0 = walk finished).
   // A debug access is one cycle of port use followed by a response phase.
   int            m_clear = 0;
   bit            m_acc = 0, m_rsp = 0;
   bit            m_req_w;
   logic [RW-1:0] m_req_a;
   logic [DW-1:0] m_req_d;
   logic [DW-1:0] m_rsp_data = '0;
   logic [DW-1:0] m_rf [32];
   initial for (int i = 0; i < 32; i++) m_rf[i] = '0;

   bit            e_we, e_stall, e_ready, e_rv, e_chk_ra1;
   logic [RW-1:0] e_wa, e_ra1;
   logic [DW-1:0] e_wd;

   always @(negedge clk) begin
      e_we = 1'b0; e_wa = '0; e_wd = '0; e_stall = 1'b1; e_ready = 1'b0;
      e_rv = 1'b0; e_ra1 = core_raddr1; e_chk_ra1 = 1'b1;
      if (!rst_n) begin
         e_chk_ra1 = 1'b0;
      end else if (m_clear != 0) begin
         e_we = 1'b1; e_wa = RW'(m_clear); e_wd = '0; e_chk_ra1 = 1'b0;
      end else if (m_acc) begin
         e_we = m_req_w && (m_req_a != '0); e_wa = m_req_a; e_wd = m_req_d; e_ra1 = m_req_a;
      end else if (m_rsp) begin
         e_rv = 1'b1;
      end else begin
         e_we = core_we; e_wa = core_waddr; e_wd = core_wdata;
         e_stall = 1'b0; e_ready = 1'b1;
      end

      check("m_stall", DW'(core_stall), DW'(e_stall));
      check("m_req_ready", DW'(dbg_req_ready), DW'(e_ready));
      check("m_rsp_valid", DW'(dbg_rsp_valid), DW'(e_rv));
      check("m_rf_we", DW'(rf_we), DW'(e_we));
      check("m_raddr2", DW'(rf_raddr2), DW'(core_raddr2));
      if (e_we) begin
         check("m_waddr", DW'(rf_waddr), DW'(e_wa));
         check("m_wdata", rf_wdata, e_wd);
      end
      if (e_chk_ra1) check("m_raddr1", DW'(rf_raddr1), DW'(e_ra1));
      if (e_rv) check("m_rsp_rdata", dbg_rsp_rdata, m_rsp_data);
      if (!rst_n) check("m_rsp_rdata_rst", dbg_rsp_rdata, '0);

      // advance model to the next cycle
      if (!rst_n) begin
         m_clear = 1; m_acc = 0; m_rsp = 0; m_rsp_data = '0;
      end else begin
         if (e_we && e_wa != '0) m_rf[e_wa] = e_wd;
         if (m_clear != 0) begin
            m_clear = (m_clear == 31) ? 0 : m_clear + 1;
         end else if (m_acc) begin
            m_rsp_data = m_req_w ? '0 : m_rf[m_req_a];
            m_acc = 0; m_rsp = 1;
         end else if (m_rsp) begin
            if (dbg_rsp_ready) m_rsp = 0;
         end else if (dbg_req_valid) begin
            m_req_w = dbg_req_write; m_req_a = dbg_req_addr; m_req_d = dbg_req_wdata;
            m_acc = 1;
         end
      end
   end

   // ---------------- directed helpers ----------------
   task automatic wait_idle();
      int t = 0;
      @(negedge clk);
      while (core_stall && t < 200) begin cyc(); @(negedge clk); t++; end
      check("wait_idle_timeout", DW'(t < 200), 32'd1);
   endtask

   // Issues one debug request (optionally with a core write to the same address in the
   // accept cycle); returns response data, stall cycle count and rf_we seen in ACCESS.
   task automatic dbg_access(input logic w, input logic [RW-1:0] a, input logic [DW-1:0] d,
                             input logic cw, input logic [DW-1:0] cd,
                             output logic [DW-1:0] rd, output int stalls, output logic acc_we);
      int t = 0;
      cyc();
      dbg_req_valid = 1'b1; dbg_req_write = w; dbg_req_addr = a; dbg_req_wdata = d;
      core_we = cw; core_waddr = a; core_wdata = cd;
      @(negedge clk);
      while (!dbg_req_ready && t < 200) begin cyc(); @(negedge clk); t++; end
      check("accept_timeout", DW'(t < 200), 32'd1);
      cyc();
      dbg_req_valid = 1'b0; core_we = 1'b0;
      @(negedge clk);
      acc_we = rf_we; stalls = 0; rd = '0; t = 0;
      while (core_stall && t < 200) begin
         stalls++;
         if (dbg_rsp_valid) rd = dbg_rsp_rdata;
         cyc(); @(negedge clk); t++;
      end
      check("access_timeout", DW'(t < 200), 32'd1);
   endtask

   logic [DW-1:0] rd;
   int            st;
   logic          aw;

   initial begin
      rst_n = 1'b0; core_raddr1 = '0; core_raddr2 = '0; core_we = 1'b0;
      core_waddr = '0; core_wdata = '0; dbg_req_valid = 1'b0; dbg_req_write = 1'b0;
      dbg_req_addr = '0; dbg_req_wdata = '0; dbg_rsp_ready = 1'b1;
      repeat (3) cyc();
      rst_n = 1'b1;
      wait_idle();

      // reset clear: preload x5, pulse reset, watch the walk
      cyc(); core_we = 1'b1; core_waddr = 5'd5; core_wdata = 32'hDEADBEEF;
      cyc(); core_we = 1'b0; core_raddr1 = 5'd5;
      @(negedge clk); check("preload_x5", rf_rdata1, 32'hDEADBEEF);
      cyc(); rst_n = 1'b0;
      @(negedge clk);
      check("rst_stall", DW'(core_stall), 32'd1);
      check("rst_we", DW'(rf_we), 32'd0);
      check("rst_ready", DW'(dbg_req_ready), 32'd0);
      cyc(); rst_n = 1'b1;
      for (int i = 1; i <= 31; i++) begin
         @(negedge clk);
         check("clr_we", DW'(rf_we), 32'd1);
         check("clr_addr", DW'(rf_waddr), DW'(i));
         check("clr_data", rf_wdata, 32'd0);
         check("clr_stall", DW'(core_stall), 32'd1);
         cyc();
      end
      @(negedge clk); check("clr_done_stall", DW'(core_stall), 32'd0);
      check("x5_cleared", rf_rdata1, 32'd0);

      // debug write then read of x7
      dbg_access(1'b1, 5'd7, 32'h12345678, 1'b0, '0, rd, st, aw);
      check("dw7_rdata", rd, 32'd0);
      check("dw7_stall", DW'(st), 32'd2);
      check("dw7_acc_we", DW'(aw), 32'd1);
      dbg_access(1'b0, 5'd7, '0, 1'b0, '0, rd, st, aw);
      check("dr7_rdata", rd, 32'h12345678);
      check("dr7_stall", DW'(st), 32'd2);

      // x0 protection
      dbg_access(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, '0, rd, st, aw);
      check("dw0_acc_we", DW'(aw), 32'd0);
      dbg_access(1'b0, 5'd0, '0, 1'b0, '0, rd, st, aw);
      check("dr0_rdata", rd, 32'd0);

      // response backpressure
      cyc(); dbg_rsp_ready = 1'b0;
      dbg_req_valid = 1'b1; dbg_req_write = 1'b0; dbg_req_addr = 5'd7;
      @(negedge clk); check("bp_ready", DW'(dbg_req_ready), 32'd1);
      cyc(); dbg_req_valid = 1'b0;
      @(negedge clk); check("bp_acc_stall", DW'(core_stall), 32'd1);
      for (int k = 0; k < 5; k++) begin
         cyc(); @(negedge clk);
         check("bp_valid", DW'(dbg_rsp_valid), 32'd1);
         check("bp_rdata", dbg_rsp_rdata, 32'h12345678);
         check("bp_stall", DW'(core_stall), 32'd1);
         check("bp_we", DW'(rf_we), 32'd0);
      end
      cyc(); dbg_rsp_ready = 1'b1;
      @(negedge clk); check("bp_valid_hs", DW'(dbg_rsp_valid), 32'd1);
      cyc(); @(negedge clk); check("bp_release", DW'(core_stall), 32'd0);

      // core write and debug read of the same register accepted together
      dbg_access(1'b0, 5'd3, '0, 1'b1, 32'h000000A5, rd, st, aw);
      check("sim_rdata", rd, 32'h000000A5);

      // reset while the response is pending
      cyc(); dbg_rsp_ready = 1'b0;
      dbg_req_valid = 1'b1; dbg_req_write = 1'b0; dbg_req_addr = 5'd3;
      cyc(); dbg_req_valid = 1'b0;
      cyc();
      @(negedge clk); check("rr_valid_before", DW'(dbg_rsp_valid), 32'd1);
      cyc(); rst_n = 1'b0;
      @(negedge clk); check("rr_valid_in_rst", DW'(dbg_rsp_valid), 32'd0);
      cyc(); rst_n = 1'b1; dbg_rsp_ready = 1'b1;
      @(negedge clk);
      check("rr_valid_after", DW'(dbg_rsp_valid), 32'd0);
      check("rr_walk_we", DW'(rf_we), 32'd1);
      check("rr_walk_addr", DW'(rf_waddr), 32'd1);
      wait_idle();

      // random traffic against the model
      for (int c = 0; c < 1500; c++) begin
         cyc();
         rst_n         = ($urandom_range(0, 299) != 0);
         core_raddr1   = RW'($urandom);
         core_raddr2   = RW'($urandom);
         core_we       = ($urandom_range(0, 1) == 1);
         core_waddr    = RW'($urandom);
         core_wdata    = $urandom;
         dbg_req_valid = ($urandom_range(0, 4) == 0);
         dbg_req_write = ($urandom_range(0, 1) == 1);
         dbg_req_addr  = RW'($urandom_range(0, 7));
         dbg_req_wdata = $urandom;
         dbg_rsp_ready = ($urandom_range(0, 4) != 0);
      end
      cyc();
      rst_n = 1'b1; core_we = 1'b0; dbg_req_valid = 1'b0; dbg_rsp_ready = 1'b1;
      wait_idle();
      cyc();
      for (int i = 1; i < 32; i++) check("final_rf", rf_mem[i], m_rf[i]);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/regfile_port_ctrl.md
# regfile_port_ctrl

Controller that owns the write port and read port 1 of the 32-entry register file and shares them between the single-cycle core and a debug requester. After reset it walks registers x1..x31 writing zero, because the register file itself has no reset. While it clears a register or serves a debug access, it holds the core with `core_stall`. It sits between the core datapath and `Registers`; all register-file address and write-control pins are driven from here.

## Interface
Parameters:
- `CLEAR_ON_RESET`, 1: 1 runs the zero-clear walk after reset; 0 goes straight to IDLE.
- Widths come from `def.h`: `REG_W` (5) and `DATA_W` (32).

Ports:
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `core_raddr1` in REG_W: core read address 1.
- `core_raddr2` in REG_W: core read address 2.
- `core_we` in 1: core write enable.
- `core_waddr` in REG_W: core write address.
- `core_wdata` in DATA_W: core write data.
- `core_stall` out 1: freezes the core's PC and state.
- `dbg_req_valid` in 1: debug request valid.
- `dbg_req_ready` out 1: debug request ready.
- `dbg_req_write` in 1: 1 = write, 0 = read.
- `dbg_req_addr` in REG_W: debug register address.
- `dbg_req_wdata` in DATA_W: debug write data.
- `dbg_rsp_valid` out 1: debug response valid.
- `dbg_rsp_ready` in 1: debug response ready.
- `dbg_rsp_rdata` out DATA_W: debug read data.
- `rf_raddr1` out REG_W: to `Registers` Readregister1.
- `rf_raddr2` out REG_W: to `Registers` Readregister2.
- `rf_we` out 1: to `Registers` RegWrite.
- `rf_waddr` out REG_W: to `Registers` Writeregister.
- `rf_wdata` out DATA_W: to `Registers` Writedata.
- `rf_rdata1` in DATA_W: from `Registers` Readdata1.

## Operation
- FSM states: CLEAR, IDLE, ACCESS, RESP. The reset state is CLEAR if `CLEAR_ON_RESET`=1, otherwise IDLE.
- `rf_raddr2` = `core_raddr2` in every state.
- `core_stall` = 1 in every state except IDLE. `core_stall` = 1 while `rst_n`=0.

CLEAR:
- A 5-bit counter starts at 1.
- Each cycle: `rf_we`=1, `rf_waddr`=counter, `rf_wdata`=0; the counter increments.
- When the counter reaches 31, that write is issued and the state goes to IDLE.
- `dbg_req_ready`=0 throughout.

IDLE:
- Core pass-through: `rf_raddr1`=`core_raddr1`, `rf_we`=`core_we`, `rf_waddr`=`core_waddr`, `rf_wdata`=`core_wdata`.
- `dbg_req_ready`=1.
- On `dbg_req_valid` & `dbg_req_ready`: latch write flag, address and write data; go to ACCESS.
- The core's write in the accept cycle still commits.

ACCESS (one cycle):
- Core write is gated off.
- `rf_raddr1` = latched address.
- Write request: `rf_we`=1 unless the address is 0, with `rf_waddr`/`rf_wdata` = latched values; the response data register is loaded with 0.
- Read request: `rf_we`=0; the response data register captures `rf_rdata1` (address 0 yields 0).
- Next state: RESP.

RESP:
- `dbg_rsp_valid`=1 and `dbg_rsp_rdata` are held stable until `dbg_rsp_ready`=1.
- On the handshake, go to IDLE.
- `rf_we`=0; `rf_raddr1`=`core_raddr1`.

Other rules:
- `dbg_rsp_rdata` is a register.
- A back-to-back debug request is accepted only after returning to IDLE, so there is at least one core cycle between debug accesses.
- Reset mid-operation: any state returns to its reset state on the next edge. A latched request is dropped, `dbg_rsp_valid` falls, and the clear walk restarts from x1.
- While `rst_n`=0: `rf_we`=0, `dbg_req_ready`=0, `dbg_rsp_valid`=0, `dbg_rsp_rdata`=0.

## Timing
- Clear latency: 31 cycles of `rf_we` after the reset-release edge. `core_stall` falls in the cycle after the x31 write.
- Debug access latency, with the accept in cycle N:
  - ACCESS in N+1.
  - `dbg_rsp_valid` from N+2.
  - IDLE, with `core_stall`=0, in the cycle after the response handshake.
- Minimum stall per debug access: 2 cycles (ACCESS + RESP with `dbg_rsp_ready`=1).
- The debug write lands on the ACCESS edge; a debug read issued right after it returns the new value.
- No combinational path from `dbg_rsp_ready` to any `rf_*` output.

## Structure
- `def.h` keeps `REG_W` and `DATA_W`.
- The new package `regfile_ctrl_pkg` holds:
  - the state enum `rfc_state_t` (CLEAR, IDLE, ACCESS, RESP);
  - `RF_LAST_IDX` = 31;
  - the request struct `dbg_req_t` (write, addr, wdata).
- No sub-module; the port mux and the FSM live in one module.
- The bench instantiates the block together with `Registers`.

## Test plan
- Reset clear:
  - Preload x5=0xDEADBEEF through the core port, pulse `rst_n` low for 1 cycle.
  - Required: 31 consecutive writes of 0 to addresses 1..31, `core_stall`=1 throughout, then x5 reads 0.
- Debug write/read:
  - Write x7=0x12345678 via debug, then read x7 via debug.
  - Required: response data 0 for the write, then 0x12345678; `core_stall` high exactly 2 cycles per access.
- x0 protection:
  - Debug write x0=0xFFFFFFFF, then read x0.
  - Required: `rf_we`=0 during the write's ACCESS; the read returns 0.
- Response backpressure:
  - Hold `dbg_rsp_ready`=0 for 5 cycles.
  - Required: `dbg_rsp_valid` and rdata stable, `core_stall`=1, no `rf_we` during those cycles.
- Simultaneous accept:
  - Core writes x3=0xA5 in the same cycle a debug read of x3 is accepted.
  - Required: the debug read returns 0xA5.
- Reset in RESP:
  - Assert `rst_n`=0 while `dbg_rsp_valid`=1.
  - Required: `dbg_rsp_valid`=0 after the edge and the clear walk restarts at x1.
